// File: rtl/frame_unpacker_pkg.sv
// Shared types and sizing for the byte-to-frame deserializer.
// Frame shape, byte count and FSM states live here.
package frame_pkg;

  localparam int LANES  = 4;
  localparam int ROWS   = 5;
  localparam int COLS   = 4;
  localparam int BITS   = 3;
  localparam int TOTAL  = LANES * ROWS * COLS * BITS;
  localparam int NBYTES = (TOTAL + 7) / 8;
  localparam int IW     = $clog2(NBYTES + 1);

  typedef logic [1:LANES][ROWS-1:0][COLS-1:0][BITS:1] frame_t;
  typedef logic [IW-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam idx_t LAST = idx_t'(NBYTES - 1);

endpackage

// File: rtl/frame_unpacker_if.sv
// Byte-in / frame-out handshake bundle.
// master drives bytes and consumes frames; slave is the unpacker.
interface frame_unpacker_if
  import frame_pkg::*;
();

  logic [7:0] in_byte;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;
  frame_t     out_word;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_byte,
    output in_sof,
    output in_valid,
    input  in_ready,
    input  out_word,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_byte,
    input  in_sof,
    input  in_valid,
    output in_ready,
    output out_word,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/frame_unpacker_out_reg.sv
// Single-entry valid/ready holding register for one frame.
// A load on the draining edge keeps valid high (no bubble).
module frame_out_reg
  import frame_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  frame_t data_i,
  input  logic   ready_i,
  output logic   valid_o,
  output frame_t data_o,
  output logic   full_o
);

  logic   valid_q, valid_d;
  frame_t data_q, data_d;

  // load wins over drain; drain only clears valid
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign full_o  = valid_q && !ready_i;

endmodule

// File: rtl/frame_unpacker.sv
// Reassembles sof-delimited byte frames into one packed word.
// Byte k lands at flattened bits [8k+7:8k]; byte 0 is the LSB.
module frame_unpacker
  import frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  frame_unpacker_if.slave  bus,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);

  state_t                state_q, state_d;
  idx_t                  idx_q, idx_d;
  logic [NBYTES*8-1:0]   buf_q, buf_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  load;
  logic                  full;
  logic                  last_byte;
  logic                  acc;
  logic                  sof_acc;
  logic                  dat_acc;
  frame_t                word;

  // next accepted byte would finish a frame
  always_comb begin
    last_byte = 1'b0;
    if (state_q == FILL && idx_q == LAST)
      last_byte = 1'b1;
    if (state_q == IDLE && NBYTES == 1 && bus.in_sof)
      last_byte = 1'b1;
  end

  assign bus.in_ready = !(last_byte && full);
  assign acc     = bus.in_valid && bus.in_ready;
  assign sof_acc = acc && bus.in_sof;
  assign dat_acc = acc && !bus.in_sof && state_q == FILL;

  // FSM next state, byte placement and completion
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (1'b1)
      sof_acc: begin
        err_d      = state_q == FILL;
        buf_d      = '0;
        buf_d[7:0] = bus.in_byte;
        if (NBYTES == 1) begin
          load    = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = FILL;
          idx_d   = idx_t'(1);
        end
      end
      dat_acc: begin
        for (int k = 0; k < NBYTES; k++)
          if (idx_q == idx_t'(k))
            buf_d[8*k +: 8] = bus.in_byte;
        if (idx_q == LAST) begin
          load    = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end
      default: ;
    endcase
  end

  assign word  = frame_t'(buf_d[TOTAL-1:0]);
  assign cnt_d = cnt_q + (load ? 8'd1 : 8'd0);

  // state, assembly buffer, error pulse, frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  frame_out_reg u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .data_i  (word),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .data_o  (bus.out_word),
    .full_o  (full)
  );

  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_frame_unpacker.sv
// Randomized bench for frame_unpacker with a byte-queue model.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_frame_unpacker;
  import frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_err;
  logic [7:0] frame_cnt;

  frame_unpacker_if bus ();

  frame_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mq[$];
  frame_t     exp_q[$];
  frame_t     got_q[$];
  int         exp_err = 0;
  int         err_seen = 0;
  int         exp_cnt = 0;
  int         stall_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready)
        got_q.push_back(bus.out_word);
      if (frame_err)
        err_seen++;
    end
  end

  task automatic model_accept(input logic [7:0] b, input logic sof);
    logic [TOTAL-1:0] f;
    if (sof) begin
      if (mq.size() != 0) exp_err++;
      mq.delete();
      mq.push_back(b);
    end else if (mq.size() != 0) begin
      mq.push_back(b);
    end
    if (mq.size() == NBYTES) begin
      for (int i = 0; i < TOTAL; i++)
        f[i] = mq[i/8][i%8];
      exp_q.push_back(frame_t'(f));
      exp_cnt = (exp_cnt + 1) % 256;
      mq.delete();
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    got_q.delete();
    exp_err  = 0;
    err_seen = 0;
    exp_cnt  = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sof);
    bus.in_byte  = b;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(b, sof);
        @(posedge clk);
        #1;
        return;
      end
      stall_cnt++;
      @(posedge clk);
      #1;
    end
    tests++;
    fails++;
    $display("FAIL send_byte timeout: in_ready=0 for 64 cycles, need 1");
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rand_frame();
    for (int k = 0; k < NBYTES; k++)
      send_byte(8'($urandom), k == 0);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_byte   = 8'h00;
    bus.in_sof    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b need 0", bus.out_valid);
    end
    tests++;
    if (bus.out_word !== frame_t'(0)) begin
      fails++;
      $display("FAIL reset_out_word got %h need 0", bus.out_word);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame_err got %b need 0", frame_err);
    end
    tests++;
    if (frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_frame_cnt got %0d need 0", frame_cnt);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b need 1", bus.in_ready);
    end
    #10;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [TOTAL-1:0] ref_w;
    ref_w = 240'h1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NBYTES; k++)
      send_byte(8'(k), k == 0);
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_valid got %b need 1", bus.out_valid);
    end
    tests++;
    if (bus.out_word !== frame_t'(ref_w)) begin
      fails++;
      $display("FAIL basic_word got %h need %h", bus.out_word, ref_w);
    end
    tests++;
    if (bus.out_word[4][0][0] !== 3'b000) begin
      fails++;
      $display("FAIL basic_elem000 got %b need 000", bus.out_word[4][0][0]);
    end
    tests++;
    if (bus.out_word[4][0][2] !== 3'b100) begin
      fails++;
      $display("FAIL basic_elem002 got %b need 100", bus.out_word[4][0][2]);
    end
    tests++;
    if (frame_cnt !== 8'd1) begin
      fails++;
      $display("FAIL basic_cnt got %0d need 1", frame_cnt);
    end
    idle(1);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_pulse got %b need 0", bus.out_valid);
    end
    idle(1);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL basic_nframes got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_frame%0d got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stall();
    logic [7:0] b29;
    do_reset();
    bus.out_ready = 1'b0;
    send_rand_frame();
    for (int k = 0; k < NBYTES - 1; k++)
      send_byte(8'($urandom), k == 0);
    b29 = 8'($urandom);
    bus.in_byte  = b29;
    bus.in_sof   = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_in_ready got %b need 0", bus.in_ready);
      end
      tests++;
      if (bus.out_word !== exp_q[0]) begin
        fails++;
        $display("FAIL stall_hold got %h need %h", bus.out_word, exp_q[0]);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release got %b need 1", bus.in_ready);
    end
    model_accept(b29, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== exp_q[1]) begin
      fails++;
      $display("FAIL stall_b2b got v=%b %h need v=1 %h",
               bus.out_valid, bus.out_word, exp_q[1]);
    end
    tests++;
    if (frame_cnt !== 8'd2) begin
      fails++;
      $display("FAIL stall_cnt got %0d need 2", frame_cnt);
    end
    idle(2);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL stall_nframes got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stall_frame%0d got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_resync();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++)
      send_byte(8'($urandom), k == 0);
    send_rand_frame();
    idle(2);
    tests++;
    if (err_seen != exp_err || exp_err != 1) begin
      fails++;
      $display("FAIL resync_err got %0d cycles need %0d", err_seen, exp_err);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL resync_nframes got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL resync_frame%0d got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_drop();
    int s0;
    s0 = stall_cnt;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++)
      send_byte(8'($urandom), 1'b0);
    idle(2);
    tests++;
    if (stall_cnt != s0) begin
      fails++;
      $display("FAIL drop_in_ready got %0d stalls need 0", stall_cnt - s0);
    end
    tests++;
    if (got_q.size() != 0) begin
      fails++;
      $display("FAIL drop_out got %0d frames need 0", got_q.size());
    end
    tests++;
    if (frame_cnt !== 8'(exp_cnt)) begin
      fails++;
      $display("FAIL drop_cnt got %0d need %0d", frame_cnt, exp_cnt);
    end
    send_rand_frame();
    idle(2);
    tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      fails++;
      $display("FAIL drop_after got %0d frames need 1", got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL drop_after got %h need %h", got_q[0], exp_q[0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 15; k++)
      send_byte(8'($urandom), k == 0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_word !== frame_t'(0)) begin
      fails++;
      $display("FAIL rstmid_out got v=%b %h need v=0 0", bus.out_valid, bus.out_word);
    end
    tests++;
    if (frame_cnt !== 8'd0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_cnt_err got %0d/%b need 0/0", frame_cnt, frame_err);
    end
    #10;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    send_rand_frame();
    idle(2);
    tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      fails++;
      $display("FAIL rstmid_frame got %0d frames need 1", got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL rstmid_frame got %h need %h", got_q[0], exp_q[0]);
    end
    tests++;
    if (frame_cnt !== 8'd1 || err_seen != 0) begin
      fails++;
      $display("FAIL rstmid_after got cnt=%0d err=%0d need 1/0", frame_cnt, err_seen);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int s0;
    int bad;
    do_reset();
    s0 = stall_cnt;
    for (int f = 0; f < 256; f++) begin
      send_rand_frame();
      if (f == 254) begin
        tests++;
        if (frame_cnt !== 8'd255) begin
          fails++;
          $display("FAIL b2b_cnt255 got %0d need 255", frame_cnt);
        end
      end
    end
    tests++;
    if (frame_cnt !== 8'(exp_cnt) || frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL b2b_wrap got %0d need 0", frame_cnt);
    end
    tests++;
    if (stall_cnt != s0) begin
      fails++;
      $display("FAIL b2b_bubbles got %0d stalls need 0", stall_cnt - s0);
    end
    idle(2);
    tests++;
    if (got_q.size() != 256 || exp_q.size() != 256) begin
      fails++;
      $display("FAIL b2b_nframes got %0d need 256", got_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_frames got %0d wrong frames need 0", bad);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_resync();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
